adex_spike_rate_monitor: RTL and testbench

- Downstream observation stage for the AdEx neuron core.
- Consumes the core's spike flag and 8-bit membrane readout, and measures per fixed window:
  - spike count
  - most recent inter-spike interval (ISI)
  - membrane peak
- Emits each window's result as a 4-byte record over a valid/ready byte stream, for the chip-level output mux or a serial packer.

---
 rtl/adex_spike_rate_monitor.sv | 125 ++++++++++++
 tb/tb_adex_spike_rate_monitor.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/adex_spike_rate_monitor.sv
// Windowed spike-rate / ISI / membrane-peak monitor for the AdEx neuron core.
// Each window closes into a 4-byte record streamed out over valid/ready.
module adex_spike_rate_monitor #(
  parameter int WINDOW_CYCLES = 1000,
  parameter int ISI_W         = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       spike_in,
  input  logic [7:0] vmem_in,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       overflow
);

  typedef struct packed {
    logic [7:0]       cnt;
    logic [ISI_W-1:0] isi;
    logic [7:0]       peak;
  } rec_t;

  typedef enum logic [2:0] {IDLE, S0, S1, S2, S3} state_t;

  logic             spike_d;
  logic [15:0]      win_cnt;
  logic [7:0]       spike_cnt;
  logic [7:0]       vmem_peak;
  logic [ISI_W-1:0] isi_timer;
  logic [ISI_W-1:0] last_isi;
  logic             first_seen;

  logic             spike_edge;
  logic             win_end;
  logic             load;
  logic [7:0]       cnt_snap;
  logic [7:0]       peak_snap;
  logic [ISI_W-1:0] isi_inc;
  logic [ISI_W-1:0] isi_next;

  rec_t   rec;
  state_t state, state_nxt;

  assign spike_edge = spike_in & ~spike_d & en;
  assign win_end    = en && (win_cnt == 16'(WINDOW_CYCLES - 1));

  // Snapshot values fold in the closing cycle so an edge/sample there lands in this window.
  assign cnt_snap  = (spike_edge && spike_cnt != 8'hFF) ? spike_cnt + 8'd1 : spike_cnt;
  assign isi_inc   = (&isi_timer) ? isi_timer : isi_timer + ISI_W'(1);
  assign isi_next  = (spike_edge && first_seen) ? isi_inc : last_isi;
  assign peak_snap = (vmem_in > vmem_peak) ? vmem_in : vmem_peak;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_d    <= 1'b0;
      win_cnt    <= '0;
      spike_cnt  <= '0;
      vmem_peak  <= '0;
      isi_timer  <= '0;
      last_isi   <= '0;
      first_seen <= 1'b0;
    end else begin
      spike_d  <= spike_in;
      last_isi <= isi_next;
      if (spike_edge) first_seen <= 1'b1;
      if (en) begin
        win_cnt   <= win_end ? '0 : win_cnt + 16'd1;
        spike_cnt <= win_end ? '0 : cnt_snap;
        vmem_peak <= win_end ? '0 : peak_snap;
        isi_timer <= spike_edge ? '0 : isi_inc;
      end
    end
  end

  // A window closing while a record is still in flight is dropped, except when
  // the final byte hands off in that same cycle.
  assign load = win_end && ((state == IDLE) || (state == S3 && out_ready));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rec      <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) rec <= {cnt_snap, isi_next, peak_snap};
      if (win_end && !load) overflow <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = 8'h00;
    case (state)
      IDLE: if (win_end) state_nxt = S0;
      S0: begin
        out_valid = 1'b1;
        out_data  = rec.cnt;
        if (out_ready) state_nxt = S1;
      end
      S1: begin
        out_valid = 1'b1;
        out_data  = rec.isi[15:8];
        if (out_ready) state_nxt = S2;
      end
      S2: begin
        out_valid = 1'b1;
        out_data  = rec.isi[7:0];
        if (out_ready) state_nxt = S3;
      end
      S3: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_data  = rec.peak;
        if (out_ready) state_nxt = win_end ? S0 : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_adex_spike_rate_monitor.sv
// Directed bench for adex_spike_rate_monitor (16-cycle windows): window table
// plus hand-built stall/drop, gapless, reset and long-ISI sequences.
module tb_adex_spike_rate_monitor;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       spike_in;
  logic [7:0] vmem_in;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       overflow;

  adex_spike_rate_monitor #(.WINDOW_CYCLES(16), .ISI_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .spike_in(spike_in), .vmem_in(vmem_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] spk;   // spike_in per window cycle
    logic        ramp;  // vmem_in = cycle index
    int          pk_i;  // else vmem_in = 3 except pk_v at pk_i
    logic [7:0]  pk_v;
    logic [31:0] exp;   // {B0,B1,B2,B3}
  } win_t;

  win_t tbl[5];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit mon_on  = 1'b1;

  logic [7:0] qd[$];
  logic       ql[$];
  int         qc[$];

  always @(negedge clk)
    if (mon_on && rst_n && out_valid && out_ready) begin
      qd.push_back(out_data);
      ql.push_back(out_last);
      qc.push_back(cyc);
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_rec(input string nm, input int idx, input logic [31:0] exp);
    if (qd.size() < idx * 4 + 4) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: only %0d bytes captured, need %0d", nm, qd.size(), idx * 4 + 4);
    end else begin
      for (int b = 0; b < 4; b++) begin
        chk($sformatf("%s B%0d", nm, b), 32'(qd[idx*4+b]), 32'(exp[31-8*b -: 8]));
        chk($sformatf("%s last%0d", nm, b), 32'(ql[idx*4+b]), 32'(b == 3));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_q();
    qd.delete();
    ql.delete();
    qc.delete();
  endtask

  task automatic do_reset();
    en = 1'b0; spike_in = 1'b0; vmem_in = 8'd0; out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;
    clear_q();
  endtask

  initial begin
    tbl[0] = '{16'h1084, 1'b1, 0,  8'd0,   32'h0300_050F};
    tbl[1] = '{16'h23F8, 1'b0, 5,  8'd200, 32'h0200_0AC8};
    tbl[2] = '{16'h8000, 1'b0, 15, 8'd77,  32'h0100_124D};
    tbl[3] = '{16'h0001, 1'b0, 8,  8'd9,   32'h0000_1209};
    tbl[4] = '{16'h0013, 1'b0, 15, 8'd255, 32'h0200_04FF};

    do_reset();
    @(negedge clk);
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst out_data", 32'(out_data), 0);
    chk("rst out_last", 32'(out_last), 0);
    chk("rst overflow", 32'(overflow), 0);

    // Table: back-to-back windows, ISI history carries across them
    tick();
    cyc = 0;
    clear_q();
    en = 1'b1;
    for (int w = 0; w < 5; w++)
      for (int i = 0; i < 16; i++) begin
        spike_in = tbl[w].spk[i];
        vmem_in  = tbl[w].ramp ? 8'(i) : ((i == tbl[w].pk_i) ? tbl[w].pk_v : 8'd3);
        tick();
      end
    spike_in = 1'b0;
    vmem_in  = 8'd3;
    repeat (8) tick();
    for (int w = 0; w < 5; w++) begin
      chk_rec($sformatf("tbl w%0d", w), w, tbl[w].exp);
      if (qc.size() >= w * 4 + 4) begin
        chk($sformatf("tbl w%0d B0 cycle", w), 32'(qc[w*4]), 32'(16 * w + 16));
        chk($sformatf("tbl w%0d B3 cycle", w), 32'(qc[w*4+3]), 32'(16 * w + 19));
      end
    end

    // Stall across window ends: hold, drop, accumulators cleared, then reset mid-S1
    do_reset();
    en = 1'b1;
    for (int c = 0; c <= 65; c++) begin
      out_ready = (c >= 40);
      spike_in  = (c == 2 || c == 6 || c == 20 || c == 50);
      vmem_in   = (c == 9) ? 8'd60 : (c == 25) ? 8'd99 : 8'd3;
      if (c == 17 || c == 39) begin
        @(negedge clk);
        chk($sformatf("stall valid c%0d", c), 32'(out_valid), 1);
        chk($sformatf("stall B0 c%0d", c), 32'(out_data), 32'h02);
        chk($sformatf("stall last c%0d", c), 32'(out_last), 0);
      end
      if (c == 30) begin
        @(negedge clk);
        chk("ovf before drop", 32'(overflow), 0);
      end
      if (c == 32) begin
        @(negedge clk);
        chk("ovf after drop", 32'(overflow), 1);
      end
      if (c == 65) begin
        #2 rst_n = 1'b0;
        #1;
        chk("midrec out_valid", 32'(out_valid), 0);
        chk("midrec overflow", 32'(overflow), 0);
        chk("midrec out_data", 32'(out_data), 0);
        break;
      end
      tick();
    end
    chk_rec("stall rec0", 0, 32'h0200_043C);
    chk_rec("stall rec1", 1, 32'h0000_0E03);
    if (qd.size() >= 9) chk("stall rec2 B0", 32'(qd[8]), 32'h01);
    else chk("stall rec2 present", 32'(qd.size()), 9);

    do_reset();
    en = 1'b1;
    for (int c = 0; c < 22; c++) begin
      spike_in = (c == 5);
      vmem_in  = 8'd3;
      tick();
    end
    chk_rec("post-rst rec", 0, 32'h0100_0003);

    // Gapless: S3 handshake coincides with the next window end
    do_reset();
    en = 1'b1;
    begin
      int gap = 0;
      for (int c = 0; c < 37; c++) begin
        out_ready = !(c >= 19 && c <= 30);
        spike_in  = (c == 3 || c == 17 || c == 25);
        vmem_in   = (c == 20) ? 8'd42 : 8'd3;
        if (c >= 16 && c <= 35) begin
          @(negedge clk);
          if (!out_valid) gap++;
        end
        if (c == 33) chk("gapless ovf", 32'(overflow), 0);
        tick();
      end
      chk("gapless valid gaps", 32'(gap), 0);
    end
    chk_rec("gapless rec0", 0, 32'h0100_0003);
    chk_rec("gapless rec1", 1, 32'h0200_082A);
    if (qc.size() >= 5) begin
      chk("gapless rec0 B3 cycle", 32'(qc[3]), 32'd31);
      chk("gapless rec1 B0 cycle", 32'(qc[4]), 32'd32);
    end

    // Long silence saturates ISI; a short gap afterwards is exact
    do_reset();
    en = 1'b1;
    mon_on = 1'b0;
    vmem_in = 8'd3;
    for (int c = 0; c <= 70120; c++) begin
      spike_in = (c == 2 || c == 70002 || c == 70102);
      if (c == 69990) begin
        clear_q();
        mon_on = 1'b1;
      end
      tick();
    end
    chk_rec("isi one-spike", 0, 32'h0000_0003);
    chk_rec("isi saturated", 1, 32'h01FF_FF03);
    chk_rec("isi exact", 7, 32'h0100_6403);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
